// File: rtl/snake_pkg.sv
// Shared definitions for the snake pixel source.
// Contents: grid geometry, direction encodings, the grid-cell struct and
// default colours. There are no ports; the other files import this package.
package snake_pkg;

   localparam int GRID_W     = 40;
   localparam int GRID_H     = 30;
   localparam int CELL_SHIFT = 4;   // 16x16 pixel cells

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   typedef struct packed {
      logic [5:0] x;
      logic [4:0] y;
   } cell_t;

   localparam logic [11:0] COL_HEAD   = 12'hFF0;
   localparam logic [11:0] COL_DEAD   = 12'hF00;
   localparam logic [11:0] COL_BODY   = 12'h0F0;
   localparam logic [11:0] COL_TARGET = 12'h00F;
   localparam logic [11:0] COL_BG     = 12'h000;

endpackage

// File: rtl/snake_next_head.sv
// Combinational one-cell move on the 40x30 grid, with wrap-around on all edges.
// Ports:
//   i_cell  current cell
//   i_dir   direction (up/right/down/left)
//   o_cell  neighbouring cell in that direction
module snake_next_head
   import snake_pkg::*;
(
   input  cell_t      i_cell,
   input  logic [1:0] i_dir,
   output cell_t      o_cell
);

   always_comb begin
      o_cell = i_cell;
      case (i_dir)
         DIR_UP:    o_cell.y = (i_cell.y == 5'd0) ? 5'(GRID_H - 1) : i_cell.y - 5'd1;
         DIR_DOWN:  o_cell.y = (i_cell.y == 5'(GRID_H - 1)) ? 5'd0 : i_cell.y + 5'd1;
         DIR_RIGHT: o_cell.x = (i_cell.x == 6'(GRID_W - 1)) ? 6'd0 : i_cell.x + 6'd1;
         default:   o_cell.x = (i_cell.x == 6'd0) ? 6'(GRID_W - 1) : i_cell.x - 6'd1;
      endcase
   end

endmodule

// File: rtl/snake_body_painter.sv
// Snake game pixel source. Holds the snake as a shift register of grid cells,
// moves it once every MOVE_DIV frames, detects target capture and
// self-collision, and produces a registered colour for each pixel address.
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   ENABLE          game running; low freezes movement
//   FRAME           one-CLK pulse per frame
//   ADDRH, ADDRV    pixel column / row
//   DIRECTION       requested direction
//   TARGET_X/Y      target cell
//   COLOUR_OUT      pixel colour, one CLK after the address
//   HEAD_X/Y        head cell
//   LENGTH          visible length
//   TARGET_REACHED  one-CLK pulse after a step lands on the target
//   DEAD            sticky self-collision flag
module snake_body_painter
   import snake_pkg::*;
#(
   parameter int          MAX_LEN       = 16,
   parameter int          INIT_LEN      = 4,
   parameter int          MOVE_DIV      = 8,
   parameter int          START_X       = 20,
   parameter int          START_Y       = 15,
   parameter logic [11:0] HEAD_COLOUR   = COL_HEAD,
   parameter logic [11:0] DEAD_COLOUR   = COL_DEAD,
   parameter logic [11:0] BODY_COLOUR   = COL_BODY,
   parameter logic [11:0] TARGET_COLOUR = COL_TARGET,
   parameter logic [11:0] BG_COLOUR     = COL_BG
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic        FRAME,
   input  logic [9:0]  ADDRH,
   input  logic [8:0]  ADDRV,
   input  logic [1:0]  DIRECTION,
   input  logic [5:0]  TARGET_X,
   input  logic [4:0]  TARGET_Y,
   output logic [11:0] COLOUR_OUT,
   output logic [5:0]  HEAD_X,
   output logic [4:0]  HEAD_Y,
   output logic [4:0]  LENGTH,
   output logic        TARGET_REACHED,
   output logic        DEAD
);

   localparam int             CW       = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(MOVE_DIV - 1);

   cell_t          r_seg [MAX_LEN];
   logic [1:0]     r_cur_dir;
   logic [1:0]     r_pending_dir;
   logic [4:0]     r_len;
   logic [CW-1:0]  r_frame_cnt;
   logic           r_dead;
   logic           r_target_reached;
   logic [11:0]    r_colour;

   cell_t          w_new_head;
   cell_t          w_target;
   cell_t          w_pix;
   logic           w_tick;
   logic           w_step;
   logic           w_collide;
   logic           w_hit_target;
   logic           w_in_range;
   logic           w_body_hit;
   logic [4:0]     w_len_grow;
   logic [11:0]    w_colour;

   // Initial body trails to the left of the head, wrapping at the grid edge.
   function automatic logic [5:0] init_x(input int i);
      int v;
      v = (START_X - i) % GRID_W;
      if (v < 0) v = v + GRID_W;
      return v[5:0];
   endfunction

   snake_next_head u_next_head (
      .i_cell (r_seg[0]),
      .i_dir  (r_pending_dir),
      .o_cell (w_new_head)
   );

   assign w_target     = '{x: TARGET_X, y: TARGET_Y};
   assign w_tick       = FRAME & ENABLE & ~r_dead;
   assign w_step       = w_tick && (r_frame_cnt == CNT_LAST);
   assign w_hit_target = (w_new_head == w_target);
   assign w_len_grow   = (r_len < 5'(MAX_LEN)) ? r_len + 5'd1 : r_len;

   // Collision is checked against the pre-shift body excluding the tail
   // cell, which vacates on the same step.
   always_comb begin
      w_collide = 1'b0;
      for (int j = 0; j < MAX_LEN - 1; j++) begin
         if ((j < int'(r_len) - 1) && (w_new_head == r_seg[j])) w_collide = 1'b1;
      end
   end

   always_comb begin
      w_pix      = '{x: 6'(ADDRH >> CELL_SHIFT), y: 5'(ADDRV >> CELL_SHIFT)};
      w_in_range = (ADDRH < 10'd640) && (ADDRV < 9'd480);
      w_body_hit = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((i < int'(r_len)) && (w_pix == r_seg[i])) w_body_hit = 1'b1;
      end
      w_colour = BG_COLOUR;
      if (!w_in_range)             w_colour = BG_COLOUR;
      else if (w_pix == r_seg[0])  w_colour = r_dead ? DEAD_COLOUR : HEAD_COLOUR;
      else if (w_body_hit)         w_colour = BODY_COLOUR;
      else if (w_pix == w_target)  w_colour = TARGET_COLOUR;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_seg[i] <= '{x: init_x(i), y: 5'(START_Y)};
         end
         r_cur_dir        <= DIR_RIGHT;
         r_pending_dir    <= DIR_RIGHT;
         r_len            <= 5'(INIT_LEN);
         r_frame_cnt      <= '0;
         r_dead           <= 1'b0;
         r_target_reached <= 1'b0;
         r_colour         <= '0;
      end else begin
         r_colour         <= w_colour;
         r_target_reached <= 1'b0;
         // Reversal is judged against the committed direction, so a
         // two-turn U within one step period only takes the first turn.
         if (DIRECTION != (r_cur_dir ^ 2'b10)) r_pending_dir <= DIRECTION;
         if (w_tick) begin
            if (r_frame_cnt == CNT_LAST) r_frame_cnt <= '0;
            else                         r_frame_cnt <= r_frame_cnt + CW'(1);
         end
         if (w_step) begin
            r_cur_dir <= r_pending_dir;
            r_seg[0]  <= w_new_head;
            for (int i = 1; i < MAX_LEN; i++) begin
               r_seg[i] <= r_seg[i-1];
            end
            if (w_collide) r_dead <= 1'b1;
            if (w_hit_target) begin
               r_len            <= w_len_grow;
               r_target_reached <= 1'b1;
            end
         end
      end
   end

   assign COLOUR_OUT     = r_colour;
   assign HEAD_X         = r_seg[0].x;
   assign HEAD_Y         = r_seg[0].y;
   assign LENGTH         = r_len;
   assign TARGET_REACHED = r_target_reached;
   assign DEAD           = r_dead;

endmodule
